// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store control, word-wide memory with read-modify-write sub-word stores
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_load_data,
  output logic              resp_misaligned,
  output logic              resp_illegal,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
  state_t state, next;
  logic [2:0] f3;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, merge, merged, ext;
  logic [7:0] b;
  logic [15:0] h;
  logic acc, st, noop, ill, mis;
  assign acc  = req_valid && state == IDLE;
  assign st   = !req_load && req_store;
  assign noop = !req_load && !req_store;
  assign ill  = req_load ? (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)
                         : st && (req_funct3[2] || req_funct3[1:0] == 2'b11);
  assign mis  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  // sub-word stores (funct3[1]==0) need the old word first
  always_comb begin
    next = state == IDLE   ? (!acc ? IDLE : (ill || mis || noop) ? DONE :
                              req_load ? LOAD : req_funct3[1] ? WRITE : RMW_RD) :
           state == LOAD   ? DONE :
           state == RMW_RD ? WRITE :
           state == WRITE  ? DONE : IDLE;
  end
  // reset gates strobes so an aborted access never writes or responds
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == DONE && !reset;
    MemRead    = (state == LOAD || state == RMW_RD) && !reset;
    MemWrite   = state == WRITE && !reset;
    mem_addr   = (state == LOAD || state == RMW_RD || state == WRITE) ? {addr[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata  = state == WRITE ? (f3[1] ? wdata : merged) : '0;
  end
  assign b   = mem_rdata[{addr[1:0], 3'b000} +: 8];
  assign h   = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ext = f3[1:0] == 2'b00 ? {{24{!f3[2] && b[7]}}, b} :
               f3[1:0] == 2'b01 ? {{16{!f3[2] && h[15]}}, h} : mem_rdata;
  always_comb begin
    merged = merge;
    if (f3[0]) merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
  end
  always_ff @(posedge clk)
    if (reset) begin
      f3              <= '0;
      addr            <= '0;
      wdata           <= '0;
      merge           <= '0;
      resp_load_data  <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
    end else begin
      if (acc) begin
        f3              <= req_funct3;
        addr            <= req_addr;
        wdata           <= req_wdata;
        resp_load_data  <= '0;
        resp_illegal    <= ill;
        resp_misaligned <= !ill && !noop && mis;
      end
      if (state == LOAD) resp_load_data <= ext;
      if (state == RMW_RD) merge <= mem_rdata;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl against a small word memory
module tb_lsu_ctrl;
  logic clk = 0, reset = 1, req_valid = 0, req_load = 0, req_store = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_misaligned, resp_illegal, MemRead, MemWrite;
  logic [31:0] resp_load_data, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:15];
  logic poke_en = 0;
  logic [3:0] poke_idx = 0;
  logic [31:0] poke_val = 0;
  logic [31:0] last_raddr = 0, last_waddr = 0, last_wdata = 0;
  logic [4:0] rdy_e, rv_e;
  int total = 0, bad = 0, nwr, nrv, nrd;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_load_data(resp_load_data), .resp_misaligned(resp_misaligned),
    .resp_illegal(resp_illegal), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk)
    if (MemWrite) mem[mem_addr[5:2]] <= mem_wdata;
    else if (poke_en) mem[poke_idx] <= poke_val;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  task automatic poke(input logic [3:0] i, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1; poke_idx = i; poke_val = v;
    @(negedge clk);
    poke_en = 0;
  endtask

  task automatic req(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int lat_e,
                     input int nrd_e, input int nwr_e, input logic dchk,
                     input logic [31:0] data_e, input logic mis_e, input logic ill_e);
    int lat = 0, rd = 0, wr = 0;
    @(negedge clk);
    chk({tag, ".rdy"}, req_ready, 1);
    req_valid = 1; req_load = ld; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clk);
      req_valid = 0;
      if (i == 1) chk({tag, ".busy"}, req_ready, 0);
      if (MemRead && MemWrite) chk({tag, ".rdwr"}, 1, 0);
      if (MemRead) begin rd++; last_raddr = mem_addr; end
      if (MemWrite) begin wr++; last_waddr = mem_addr; last_wdata = mem_wdata; end
      if (resp_valid) lat = i;
    end
    chk({tag, ".lat"}, lat, lat_e);
    chk({tag, ".nrd"}, rd, nrd_e);
    chk({tag, ".nwr"}, wr, nwr_e);
    chk({tag, ".mis"}, resp_misaligned, mis_e);
    chk({tag, ".ill"}, resp_illegal, ill_e);
    if (dchk) chk({tag, ".data"}, resp_load_data, data_e);
    @(negedge clk);
    chk({tag, ".pulse"}, resp_valid, 0);
    chk({tag, ".ready"}, req_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.ready", req_ready, 1);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.memread", MemRead, 0);
    chk("rst.memwrite", MemWrite, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.data", resp_load_data, 0);
    chk("rst.flags", {resp_misaligned, resp_illegal}, 0);
    reset = 0;
    poke(4, 32'h8070F0A5);
    poke(5, 32'h0);
    req("lb", 1, 0, 3'b000, 32'h11, 0, 2, 1, 0, 1, 32'hFFFFFFF0, 0, 0);
    chk("lb.addr", last_raddr, 32'h10);
    req("lbu", 1, 0, 3'b100, 32'h11, 0, 2, 1, 0, 1, 32'h000000F0, 0, 0);
    req("lh", 1, 0, 3'b001, 32'h12, 0, 2, 1, 0, 1, 32'hFFFF8070, 0, 0);
    chk("lh.addr", last_raddr, 32'h10);
    req("lhu", 1, 0, 3'b101, 32'h12, 0, 2, 1, 0, 1, 32'h00008070, 0, 0);
    req("sb", 0, 1, 3'b000, 32'h13, 32'h12345655, 3, 1, 1, 0, 0, 0, 0);
    chk("sb.waddr", last_waddr, 32'h10);
    chk("sb.wdata", last_wdata, 32'h5570F0A5);
    chk("sb.mem", mem[4], 32'h5570F0A5);
    req("lw", 1, 0, 3'b010, 32'h10, 0, 2, 1, 0, 1, 32'h5570F0A5, 0, 0);
    poke(4, 32'h8070F0A5);
    req("sh", 0, 1, 3'b001, 32'h10, 32'h0000BEEF, 3, 1, 1, 0, 0, 0, 0);
    chk("sh.wdata", last_wdata, 32'h8070BEEF);
    chk("sh.mem", mem[4], 32'h8070BEEF);
    req("sw", 0, 1, 3'b010, 32'h14, 32'hDEADBEEF, 2, 0, 1, 0, 0, 0, 0);
    chk("sw.waddr", last_waddr, 32'h14);
    chk("sw.mem", mem[5], 32'hDEADBEEF);
    req("mis_lw", 1, 0, 3'b010, 32'h12, 0, 1, 0, 0, 0, 0, 1, 0);
    req("mis_sh", 0, 1, 3'b001, 32'h11, 32'hFFFF, 1, 0, 0, 0, 0, 1, 0);
    req("mis_lh", 1, 0, 3'b001, 32'h13, 0, 1, 0, 0, 0, 0, 1, 0);
    chk("mis.mem", mem[4], 32'h8070BEEF);
    req("ill_ld", 1, 0, 3'b011, 32'h10, 0, 1, 0, 0, 0, 0, 0, 1);
    req("ill_st", 0, 1, 3'b100, 32'h13, 32'h1, 1, 0, 0, 0, 0, 0, 1);
    req("ill_prec", 1, 0, 3'b110, 32'h12, 0, 1, 0, 0, 0, 0, 0, 1);
    req("both", 1, 1, 3'b010, 32'h10, 32'h0, 2, 1, 0, 1, 32'h8070BEEF, 0, 0);
    req("noop", 0, 0, 3'b010, 32'h12, 0, 1, 0, 0, 1, 0, 0, 0);
    chk("ill.mem", mem[4], 32'h8070BEEF);
    @(negedge clk);
    req_valid = 1; req_load = 0; req_store = 1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h77;
    @(negedge clk);
    req_valid = 0;
    chk("rst_mid.memread", MemRead, 1);
    reset = 1;
    @(negedge clk);
    chk("rst_mid.memwrite", MemWrite, 0);
    chk("rst_mid.resp", resp_valid, 0);
    reset = 0;
    @(negedge clk);
    chk("rst_mid.ready", req_ready, 1);
    nwr = 0; nrv = 0;
    repeat (4) begin
      @(negedge clk);
      nwr += MemWrite;
      nrv += resp_valid;
    end
    chk("rst_mid.nwr", nwr, 0);
    chk("rst_mid.nrv", nrv, 0);
    chk("rst_mid.mem", mem[4], 32'h8070BEEF);
    rdy_e = 5'b00100;
    rv_e = 5'b10010;
    nrd = 0;
    @(negedge clk);
    req_valid = 1; req_load = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("b2b.ready%0d", i), req_ready, rdy_e[i]);
      chk($sformatf("b2b.resp%0d", i), resp_valid, rv_e[i]);
      nrd += MemRead;
      if (rv_e[i]) chk($sformatf("b2b.data%0d", i), resp_load_data, 32'h8070BEEF);
    end
    req_valid = 0;
    chk("b2b.nrd", nrd, 2);
    @(negedge clk);
    chk("b2b.idle", req_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store control unit between the MEM-stage pipeline register and the word-addressed data memory.
- Converts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide MemRead/MemWrite accesses.
- Sub-word stores are done as read-modify-write. Loads are sign- or zero-extended, and misaligned or illegal requests are flagged.
- Pipeline stalls while req_ready is low.

Parameters:
ADDR_W, 32, width of req_addr and mem_addr

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
req_valid  in  1  request present this cycle
req_ready  out  1  unit can accept a request (high only in IDLE)
req_load  in  1  request is a load
req_store  in  1  request is a store
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2), low bits significant for SB/SH
resp_valid  out  1  one-cycle pulse: request complete
resp_load_data  out  32  extended load result, valid with resp_valid
resp_misaligned  out  1  address misaligned for access size, valid with resp_valid
resp_illegal  out  1  unsupported funct3, valid with resp_valid
MemRead  out  1  read enable to data memory
MemWrite  out  1  write enable to data memory (sampled on clk edge)
mem_addr  out  ADDR_W  word address to memory, bits [1:0] always 0
mem_wdata  out  32  write word to memory
mem_rdata  in  32  asynchronous read data from memory, valid same cycle as MemRead

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- Reset state: IDLE. At reset all outputs are 0 except req_ready, which is 1.
- Accept condition: req_valid && req_ready in IDLE.
  - On accept, funct3, addr, wdata and type are registered.
  - Inputs are ignored outside IDLE.
- Type rules:
  - req_load takes priority if both req_load and req_store are set.
  - Neither set: go to DONE with no memory access, all resp flags 0, resp_load_data 0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3: resp_illegal=1, no access.
- Misalignment:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Misaligned request: resp_misaligned=1, no MemRead/MemWrite.
  - Illegal takes precedence over misaligned.
- Transitions from IDLE on accept:
  - Illegal, misaligned or no-op request -> DONE.
  - Load -> LOAD.
  - SW -> WRITE.
  - SB/SH -> RMW_RD.
- LOAD:
  - MemRead=1, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Select byte addr[1:0] or half addr[1] from mem_rdata; sign-extend (LB/LH) or zero-extend (LBU/LHU); register into resp_load_data.
  - -> DONE.
- RMW_RD:
  - MemRead=1 at the word address; capture mem_rdata into a merge register.
  - -> WRITE.
- WRITE:
  - MemWrite=1 for exactly one cycle.
  - mem_wdata is req_wdata for SW, or the merged word for SB/SH: wdata[7:0] into byte lane addr[1:0], or wdata[15:0] into half lane addr[1], other lanes unchanged.
  - -> DONE.
- DONE:
  - resp_valid=1 for one cycle; flags and load data are held stable until the next accept.
  - -> IDLE. req_ready=1 again the following cycle.
- MemRead and MemWrite are never high together. Both are 0 in IDLE and DONE.
- Latency from the accept edge to resp_valid:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error or no-op: 1 cycle.
- Back-to-back requests: the earliest next accept is the cycle after DONE. No overlap.
- Reset mid-operation:
  - Next state is IDLE; MemWrite is 0 on the cycle reset is sampled and after.
  - An interrupted RMW performs no partial write.
  - resp_valid is not generated for the aborted request.
- No response backpressure: the consumer must take resp_valid when it pulses.

Test Plan:
- Preload word 0x10 = 0x8070F0A5.
  - LB 0x11 -> resp_load_data 0xFFFFFFF0.
  - LBU 0x11 -> 0x000000F0.
  - LH 0x12 -> 0xFFFF8070.
  - LHU 0x12 -> 0x00008070.
  - Each load: resp_valid exactly 2 cycles after accept; MemRead high 1 cycle with mem_addr 0x10.
- SB addr 0x13 wdata 0x123456_55 on word 0x8070F0A5:
  - RMW_RD then WRITE, mem_wdata 0x5570F0A5, resp_valid 3 cycles after accept.
  - Follow-up LW 0x10 returns 0x5570F0A5.
- SH addr 0x10 wdata 0x0000BEEF -> word becomes 0x8070BEEF. SW 0x14 0xDEADBEEF -> single MemWrite, 2-cycle latency.
- LW 0x12, SH 0x11, LH 0x13:
  - resp_misaligned=1 one cycle after accept; MemRead and MemWrite stay 0; memory unchanged.
- funct3=011 load and funct3=100 store -> resp_illegal=1, resp_misaligned=0, no memory access.
- Assert reset during RMW_RD of SB 0x10:
  - No MemWrite occurs, word unchanged, no resp_valid.
  - req_ready=1 the cycle after reset deasserts.
  - Back-to-back LW requests held on req_valid are accepted only in IDLE; req_ready is low for LOAD and DONE.
